// File: rtl/mac_pkg.sv
// Shared defaults and FSM state type for the sequencing MAC accumulator.
package mac_pkg;

    localparam int BW_DEF      = 4;
    localparam int PSUM_BW_DEF = 16;
    localparam int LEN_DEF     = 8;

    typedef enum logic {
        ACC   = 1'b0,
        DRAIN = 1'b1
    } state_t;

endpackage

// File: rtl/mac_acc_seq_if.sv
// Pair-in / psum-out handshake bundle for mac_acc_seq; the slave modport is the accumulator side.
interface mac_acc_seq_if import mac_pkg::*; #(
    parameter int BW      = BW_DEF,
    parameter int PSUM_BW = PSUM_BW_DEF
);

    // valid/ready: a transfer happens on a rising edge where valid && ready; the
    // sender holds valid and data stable until then, and ready may depend on valid.
    logic               in_valid;
    logic               in_ready;
    logic [BW-1:0]      in_a;
    logic [BW-1:0]      in_b;
    logic               out_valid;
    logic               out_ready;
    logic [PSUM_BW-1:0] out_psum;
    logic               out_ovf;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_psum, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_psum, out_ovf
    );

endinterface

// File: rtl/mac_acc_add.sv
// Combinational product (unsigned a x signed b) plus running psum with overflow detect.
// Define MAC_ACC_SAT_EN to clamp each add instead of wrapping.
module mac_acc_add import mac_pkg::*; #(
    parameter int BW      = BW_DEF,
    parameter int PSUM_BW = PSUM_BW_DEF
) (
    input  logic [BW-1:0]      a,
    input  logic [BW-1:0]      b,
    input  logic [PSUM_BW-1:0] base,
    output logic [PSUM_BW-1:0] sum,
    output logic               ovf
);

    logic [PSUM_BW-1:0] a_ext;
    logic [PSUM_BW-1:0] b_ext;
    logic [PSUM_BW-1:0] product;
    logic [PSUM_BW:0]   wide;
    logic               wrap_ovf;

    assign a_ext = {{(PSUM_BW-BW){1'b0}}, a};
    assign b_ext = {{(PSUM_BW-BW){b[BW-1]}}, b};
    // The low PSUM_BW bits of a product are identical for signed and unsigned operands.
    assign product = a_ext * b_ext;

    assign wide     = {base[PSUM_BW-1], base} + {product[PSUM_BW-1], product};
    assign wrap_ovf = wide[PSUM_BW] ^ wide[PSUM_BW-1];
    assign ovf      = wrap_ovf;

`ifdef MAC_ACC_SAT_EN
    localparam logic [PSUM_BW-1:0] SAT_MAX = {1'b0, {(PSUM_BW-1){1'b1}}};
    localparam logic [PSUM_BW-1:0] SAT_MIN = {1'b1, {(PSUM_BW-1){1'b0}}};

    // The extra top bit of wide is the true sign, so it picks the clamp direction.
    always_comb begin
        sum = wide[PSUM_BW-1:0];
        if (wrap_ovf) begin
            sum = wide[PSUM_BW] ? SAT_MIN : SAT_MAX;
        end
    end
`else
    assign sum = wide[PSUM_BW-1:0];
`endif

endmodule

// File: rtl/mac_acc_seq.sv
// Accumulates LEN (activation, weight) products per vector and emits one signed psum.
// Optional MAC_ACC_SAT_EN selects saturating adds (see mac_acc_add).
module mac_acc_seq import mac_pkg::*; #(
    parameter int BW      = BW_DEF,
    parameter int PSUM_BW = PSUM_BW_DEF,
    parameter int LEN     = LEN_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    mac_acc_seq_if.slave            bus,
    output state_t                  dbg_state,
    output logic [$clog2(LEN)-1:0]  dbg_cnt,
    output logic [PSUM_BW-1:0]      dbg_psum
);

    localparam int               CNT_W = $clog2(LEN);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(LEN - 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [PSUM_BW-1:0] psum;
    logic               ovf_acc;

    logic               accept;
    logic               first;
    logic [PSUM_BW-1:0] base;
    logic [PSUM_BW-1:0] sum;
    logic               add_ovf;
    logic               ovf_next;

    // DRAIN passes out_ready straight through so term 0 of the next vector overlaps the result handoff.
    assign bus.in_ready = (state == ACC) ? 1'b1 : bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    assign first    = (cnt == '0);
    assign base     = first ? '0 : psum;
    assign ovf_next = (!first && ovf_acc) || add_ovf;

    mac_acc_add #(
        .BW      (BW),
        .PSUM_BW (PSUM_BW)
    ) u_add (
        .a    (bus.in_a),
        .b    (bus.in_b),
        .base (base),
        .sum  (sum),
        .ovf  (add_ovf)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ACC;
            cnt           <= '0;
            psum          <= '0;
            ovf_acc       <= 1'b0;
            bus.out_psum  <= '0;
            bus.out_ovf   <= 1'b0;
            bus.out_valid <= 1'b0;
        end else begin
            case (state)
                ACC: begin
                    if (accept) begin
                        psum    <= sum;
                        ovf_acc <= ovf_next;
                        if (cnt == LAST) begin
                            cnt           <= '0;
                            bus.out_psum  <= sum;
                            bus.out_ovf   <= ovf_next;
                            bus.out_valid <= 1'b1;
                            state         <= DRAIN;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        state         <= ACC;
                        if (accept) begin
                            psum    <= sum;
                            ovf_acc <= ovf_next;
                            cnt     <= CNT_W'(1);
                        end else begin
                            cnt <= '0;
                        end
                    end
                end
                default: state <= ACC;
            endcase
        end
    end

    assign dbg_state = state;
    assign dbg_cnt   = cnt;
    assign dbg_psum  = psum;

endmodule

// File: tb/tb_mac_acc_seq.sv
// Directed bench for mac_acc_seq: three instances (LEN=4/16b, LEN=4/8b, LEN=8/16b) sharing one stimulus port.
module tb_mac_acc_seq;
    import mac_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       out_ready;
    logic [3:0] in_a;
    logic [3:0] in_b;
    int         sel;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    mac_acc_seq_if #(.BW(4), .PSUM_BW(16)) bus_a ();
    mac_acc_seq_if #(.BW(4), .PSUM_BW(8))  bus_b ();
    mac_acc_seq_if #(.BW(4), .PSUM_BW(16)) bus_c ();

    assign bus_a.in_valid  = in_valid && (sel == 0);
    assign bus_b.in_valid  = in_valid && (sel == 1);
    assign bus_c.in_valid  = in_valid && (sel == 2);
    assign bus_a.in_a      = in_a;
    assign bus_b.in_a      = in_a;
    assign bus_c.in_a      = in_a;
    assign bus_a.in_b      = in_b;
    assign bus_b.in_b      = in_b;
    assign bus_c.in_b      = in_b;
    assign bus_a.out_ready = out_ready;
    assign bus_b.out_ready = out_ready;
    assign bus_c.out_ready = out_ready;

    state_t      dbg_state_a, dbg_state_b, dbg_state_c;
    logic [1:0]  dbg_cnt_a, dbg_cnt_b;
    logic [2:0]  dbg_cnt_c;
    logic [15:0] dbg_psum_a, dbg_psum_c;
    logic [7:0]  dbg_psum_b;

    mac_acc_seq #(.BW(4), .PSUM_BW(16), .LEN(4)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a),
        .dbg_state(dbg_state_a), .dbg_cnt(dbg_cnt_a), .dbg_psum(dbg_psum_a)
    );
    mac_acc_seq #(.BW(4), .PSUM_BW(8), .LEN(4)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b),
        .dbg_state(dbg_state_b), .dbg_cnt(dbg_cnt_b), .dbg_psum(dbg_psum_b)
    );
    mac_acc_seq #(.BW(4), .PSUM_BW(16), .LEN(8)) dut_c (
        .clk(clk), .reset(reset), .bus(bus_c),
        .dbg_state(dbg_state_c), .dbg_cnt(dbg_cnt_c), .dbg_psum(dbg_psum_c)
    );

    logic        cur_in_ready;
    logic        cur_out_valid;
    logic        cur_ovf;
    logic [15:0] cur_psum;
    logic [15:0] cur_dbg_psum;
    int          cur_cnt;
    state_t      cur_state;

    always_comb begin
        cur_in_ready  = bus_a.in_ready;
        cur_out_valid = bus_a.out_valid;
        cur_ovf       = bus_a.out_ovf;
        cur_psum      = bus_a.out_psum;
        cur_dbg_psum  = dbg_psum_a;
        cur_cnt       = int'(dbg_cnt_a);
        cur_state     = dbg_state_a;
        if (sel == 1) begin
            cur_in_ready  = bus_b.in_ready;
            cur_out_valid = bus_b.out_valid;
            cur_ovf       = bus_b.out_ovf;
            cur_psum      = {{8{bus_b.out_psum[7]}}, bus_b.out_psum};
            cur_dbg_psum  = {{8{dbg_psum_b[7]}}, dbg_psum_b};
            cur_cnt       = int'(dbg_cnt_b);
            cur_state     = dbg_state_b;
        end else if (sel == 2) begin
            cur_in_ready  = bus_c.in_ready;
            cur_out_valid = bus_c.out_valid;
            cur_ovf       = bus_c.out_ovf;
            cur_psum      = bus_c.out_psum;
            cur_dbg_psum  = dbg_psum_c;
            cur_cnt       = int'(dbg_cnt_c);
            cur_state     = dbg_state_c;
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Presents one pair and returns #1 after the negedge following its acceptance.
    task automatic send(input logic [3:0] a, input logic [3:0] b);
        int n = 0;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        #1;
        while (!cur_in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (!cur_in_ready) begin
            errors++;
            $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", cur_in_ready, n);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        sel = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        checks += 8;
        if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", bus_a.out_valid); end
        if (bus_a.out_psum !== 16'h0000) begin errors++; $display("FAIL reset_out_psum: got %h required 0000", bus_a.out_psum); end
        if (bus_a.out_ovf !== 1'b0) begin errors++; $display("FAIL reset_out_ovf: got %b required 0", bus_a.out_ovf); end
        if (bus_a.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b required 1", bus_a.in_ready); end
        if (dbg_state_a !== ACC) begin errors++; $display("FAIL reset_state: got %0d required ACC", dbg_state_a); end
        if (dbg_cnt_a !== 2'd0) begin errors++; $display("FAIL reset_cnt: got %0d required 0", dbg_cnt_a); end
        if (bus_b.out_valid !== 1'b0) begin errors++; $display("FAIL reset_b_out_valid: got %b required 0", bus_b.out_valid); end
        if (bus_c.out_valid !== 1'b0) begin errors++; $display("FAIL reset_c_out_valid: got %b required 0", bus_c.out_valid); end
    endtask

    task automatic test_basic();
        sel = 0;
        out_ready = 1'b1;
        send(4'd1, 4'd1);
        send(4'd2, 4'd1);
        send(4'd3, 4'd1);
        checks += 2;
        if (cur_out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b required 0", cur_out_valid); end
        if (cur_dbg_psum !== 16'd6) begin errors++; $display("FAIL basic_partial: got %0d required 6", cur_dbg_psum); end
        send(4'd4, 4'd1);
        checks += 4;
        if (cur_out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b required 1", cur_out_valid); end
        if (cur_psum !== 16'd10) begin errors++; $display("FAIL basic_psum: got %h required 000a", cur_psum); end
        if (cur_ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %b required 0", cur_ovf); end
        if (cur_state !== DRAIN) begin errors++; $display("FAIL basic_state: got %0d required DRAIN", cur_state); end
        tick();
        #1;
        checks++;
        if (cur_out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop: got %b required 0", cur_out_valid); end
    endtask

    task automatic test_negative();
        sel = 0;
        out_ready = 1'b1;
        repeat (4) send(4'd15, 4'h8);
        checks += 3;
        if (cur_out_valid !== 1'b1) begin errors++; $display("FAIL neg_valid: got %b required 1", cur_out_valid); end
        if (cur_psum !== 16'hFE20) begin errors++; $display("FAIL neg_psum: got %h required fe20", cur_psum); end
        if (cur_ovf !== 1'b0) begin errors++; $display("FAIL neg_ovf: got %b required 0", cur_ovf); end
        tick();
    endtask

    task automatic test_backpressure();
        sel = 0;
        out_ready = 1'b0;
        send(4'd1, 4'd2);
        send(4'd2, 4'd2);
        send(4'd3, 4'd2);
        send(4'd4, 4'd2);
        in_a     = 4'd5;
        in_b     = 4'd1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks += 4;
            if (cur_out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b required 1", i, cur_out_valid); end
            if (cur_psum !== 16'd20) begin errors++; $display("FAIL bp_psum[%0d]: got %h required 0014", i, cur_psum); end
            if (cur_in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b required 0", i, cur_in_ready); end
            if (cur_cnt !== 0) begin errors++; $display("FAIL bp_cnt[%0d]: got %0d required 0", i, cur_cnt); end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (cur_in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b required 1", cur_in_ready); end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks += 3;
        if (cur_out_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_drop: got %b required 0", cur_out_valid); end
        if (cur_cnt !== 1) begin errors++; $display("FAIL bp_term0_cnt: got %0d required 1", cur_cnt); end
        if (cur_dbg_psum !== 16'd5) begin errors++; $display("FAIL bp_term0_psum: got %0d required 5", cur_dbg_psum); end
        repeat (3) send(4'd1, 4'd1);
        checks += 2;
        if (cur_out_valid !== 1'b1) begin errors++; $display("FAIL bp_next_valid: got %b required 1", cur_out_valid); end
        if (cur_psum !== 16'd8) begin errors++; $display("FAIL bp_next_psum: got %h required 0008", cur_psum); end
        tick();
    endtask

    task automatic test_overflow();
        logic [15:0] exp_psum;
`ifdef MAC_ACC_SAT_EN
        exp_psum = 16'h007F;
`else
        exp_psum = 16'hFFA4;
`endif
        sel = 1;
        out_ready = 1'b1;
        repeat (4) send(4'd15, 4'd7);
        checks += 3;
        if (cur_out_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid: got %b required 1", cur_out_valid); end
        if (cur_psum !== exp_psum) begin errors++; $display("FAIL ovf_psum: got %h required %h", cur_psum, exp_psum); end
        if (cur_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b required 1", cur_ovf); end
        tick();
        repeat (4) send(4'd1, 4'd1);
        checks += 2;
        if (cur_psum !== 16'd4) begin errors++; $display("FAIL ovf_next_psum: got %h required 0004", cur_psum); end
        if (cur_ovf !== 1'b0) begin errors++; $display("FAIL ovf_cleared: got %b required 0", cur_ovf); end
        tick();
    endtask

    task automatic test_reset_mid();
        sel = 0;
        out_ready = 1'b1;
        send(4'd7, 4'd7);
        send(4'd7, 4'd7);
        checks++;
        if (cur_cnt !== 2) begin errors++; $display("FAIL rst_mid_cnt_before: got %0d required 2", cur_cnt); end
        reset = 1'b1;
        #1;
        checks += 2;
        if (cur_cnt !== 0) begin errors++; $display("FAIL rst_mid_cnt: got %0d required 0", cur_cnt); end
        if (cur_dbg_psum !== 16'd0) begin errors++; $display("FAIL rst_mid_psum: got %0d required 0", cur_dbg_psum); end
        tick();
        reset = 1'b0;
        #1;
        repeat (4) send(4'd1, 4'd2);
        checks += 2;
        if (cur_out_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_valid: got %b required 1", cur_out_valid); end
        if (cur_psum !== 16'd8) begin errors++; $display("FAIL rst_mid_psum_out: got %h required 0008", cur_psum); end
        tick();
    endtask

    task automatic test_gaps();
        logic [3:0] ta [8] = '{4'd3, 4'd15, 4'd0, 4'd7, 4'd9, 4'd1, 4'd12, 4'd5};
        logic [3:0] tb [8] = '{4'hE, 4'd7, 4'd5, 4'h8, 4'd3, 4'hF, 4'd4, 4'd6};
        int exp_run = 0;
        int gap;
        sel = 2;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(ta[i], tb[i]);
            exp_run += int'(ta[i]) * int'($signed(tb[i]));
            if (i < 7) begin
                gap = $urandom_range(1, 3);
                for (int g = 0; g < gap; g++) begin
                    checks += 2;
                    if (cur_cnt !== i + 1) begin errors++; $display("FAIL gap_cnt[%0d]: got %0d required %0d", i, cur_cnt, i + 1); end
                    if (cur_dbg_psum !== 16'(exp_run)) begin errors++; $display("FAIL gap_psum[%0d]: got %h required %h", i, cur_dbg_psum, 16'(exp_run)); end
                    tick();
                    #1;
                end
            end
        end
        checks += 3;
        if (cur_out_valid !== 1'b1) begin errors++; $display("FAIL gap_valid: got %b required 1", cur_out_valid); end
        if (cur_psum !== 16'd147) begin errors++; $display("FAIL gap_psum_out: got %h required 0093", cur_psum); end
        if (cur_ovf !== 1'b0) begin errors++; $display("FAIL gap_ovf: got %b required 0", cur_ovf); end
        tick();
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_a      = 4'd0;
        in_b      = 4'd0;
        sel       = 0;
        test_reset();
        test_basic();
        test_negative();
        test_backpressure();
        test_overflow();
        test_reset_mid();
        test_gaps();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
